vmu_spm_arbiter: RTL and testbench

//   Round-robin arbiter that shares one SPM read/write port among the NUM_REQ LSU

---
 rtl/vmu_spm_arbiter.sv | 99 +++++++++
 tb/tb_vmu_spm_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vmu_spm_arbiter.sv
// Round-robin arbiter sharing one SPM read/write port among NUM_REQ LSU channels,
// with registered SPM command outputs and tagged read-data return routing.
module vmu_spm_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int MEMR_DELAY = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               i_req_vld,
   input  logic [NUM_REQ-1:0]               i_req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
   output logic [NUM_REQ-1:0]               o_req_gnt,
   output logic [NUM_REQ-1:0]               o_rsp_vld,
   output logic [DATA_WIDTH-1:0]            o_rsp_rdata,
   output logic                             o_vmu_spm_rden,
   output logic                             o_vmu_spm_wren,
   output logic [ADDR_WIDTH-1:0]            o_vmu_spm_rdaddr,
   output logic [ADDR_WIDTH-1:0]            o_vmu_spm_wraddr,
   output logic [DATA_WIDTH-1:0]            o_vmu_spm_wdata,
   input  logic [DATA_WIDTH-1:0]            i_spm_rdata,
   output logic [CNT_WIDTH-1:0]             o_conflict_cnt
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
   logic [PW-1:0]                      ptr, win, idx;
   logic                               any_vld;
   logic                               multi_vld;

   // Read tag pipe: stage 0 is loaded at the grant edge, stage MEMR_DELAY
   // lines up with the SPM data.
   logic [MEMR_DELAY:0]                vld_pipe;
   logic [MEMR_DELAY:0][PW-1:0]        tag_pipe;

   assign addr_a  = i_req_addr;
   assign wdata_a = i_req_wdata;

   // Scan from furthest to nearest so the channel closest to ptr wins last.
   always_comb begin
      win     = ptr;
      idx     = ptr;
      any_vld = 1'b0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_REQ);
         if (i_req_vld[idx]) begin
            win     = idx;
            any_vld = 1'b1;
         end
      end
   end

   assign o_req_gnt   = any_vld ? (NUM_REQ'(1) << win) : '0;
   assign multi_vld   = |(i_req_vld & (i_req_vld - NUM_REQ'(1)));
   assign o_rsp_rdata = i_spm_rdata;

   always_comb begin
      o_rsp_vld = '0;
      if (vld_pipe[MEMR_DELAY]) o_rsp_vld[tag_pipe[MEMR_DELAY]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr              <= '0;
         o_vmu_spm_rden   <= 1'b0;
         o_vmu_spm_wren   <= 1'b0;
         o_vmu_spm_rdaddr <= '0;
         o_vmu_spm_wraddr <= '0;
         o_vmu_spm_wdata  <= '0;
         vld_pipe         <= '0;
         tag_pipe         <= '0;
         o_conflict_cnt   <= '0;
      end else begin
         o_vmu_spm_rden <= 1'b0;
         o_vmu_spm_wren <= 1'b0;
         if (any_vld) begin
            ptr <= (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
            if (i_req_we[win]) begin
               o_vmu_spm_wren   <= 1'b1;
               o_vmu_spm_wraddr <= addr_a[win];
               o_vmu_spm_wdata  <= wdata_a[win];
            end else begin
               o_vmu_spm_rden   <= 1'b1;
               o_vmu_spm_rdaddr <= addr_a[win];
            end
         end
         vld_pipe <= {vld_pipe[MEMR_DELAY-1:0], any_vld & ~i_req_we[win]};
         tag_pipe <= {tag_pipe[MEMR_DELAY-1:0], win};
         if (multi_vld && o_conflict_cnt != '1)
            o_conflict_cnt <= o_conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vmu_spm_arbiter.sv
// Directed bench for vmu_spm_arbiter: grants, command timing, read return,
// reset flush and conflict counter saturation (second instance, CNT_WIDTH=4).
module tb_vmu_spm_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req_vld, req_we;
   logic [3:0][31:0]  req_addr;
   logic [3:0][63:0]  req_wdata;
   logic [63:0]       spm_rdata;

   logic [3:0]  gnt, rsp_vld;
   logic [63:0] rsp_rdata, wdata;
   logic        rden, wren;
   logic [31:0] rdaddr, wraddr;
   logic [15:0] cnt;

   logic [3:0]  s_gnt, s_rsp_vld;
   logic [63:0] s_rsp_rdata, s_wdata;
   logic        s_rden, s_wren;
   logic [31:0] s_rdaddr, s_wraddr;
   logic [3:0]  s_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vmu_spm_arbiter dut (
      .clk(clk), .rst_n(rst_n), .i_req_vld(req_vld), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_gnt(gnt),
      .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata), .o_vmu_spm_rden(rden),
      .o_vmu_spm_wren(wren), .o_vmu_spm_rdaddr(rdaddr), .o_vmu_spm_wraddr(wraddr),
      .o_vmu_spm_wdata(wdata), .i_spm_rdata(spm_rdata), .o_conflict_cnt(cnt));

   vmu_spm_arbiter #(.CNT_WIDTH(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .i_req_vld(req_vld), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_gnt(s_gnt),
      .o_rsp_vld(s_rsp_vld), .o_rsp_rdata(s_rsp_rdata), .o_vmu_spm_rden(s_rden),
      .o_vmu_spm_wren(s_wren), .o_vmu_spm_rdaddr(s_rdaddr), .o_vmu_spm_wraddr(s_wraddr),
      .o_vmu_spm_wdata(s_wdata), .i_spm_rdata(spm_rdata), .o_conflict_cnt(s_cnt));

   // SPM model: 2-cycle read latency; unwritten locations return a tagged pattern.
   logic [63:0]  mem [256];
   logic [255:0] wr_seen = '0;
   logic [63:0]  spm_p1, spm_p2;
   always @(posedge clk) begin
      if (wren) begin
         mem[wraddr[7:0]]     <= wdata;
         wr_seen[wraddr[7:0]] <= 1'b1;
      end
      spm_p1 <= wr_seen[rdaddr[7:0]] ? mem[rdaddr[7:0]] : {32'hC0DE0000, 24'h0, rdaddr[7:0]};
      spm_p2 <= spm_p1;
   end
   assign spm_rdata = spm_p2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      req_vld = '0;
      req_we  = '0;
      rst_n   = 1'b0;
      tick();
      rst_n   = 1'b1;
   endtask

   initial begin
      req_addr  = '0;
      req_wdata = '0;
      do_reset();
      tick();
      chk("rst_rden",  64'(rden), 64'd0);
      chk("rst_wren",  64'(wren), 64'd0);
      chk("rst_rsp",   64'(rsp_vld), 64'd0);
      chk("rst_cnt",   64'(cnt), 64'd0);
      chk("rst_gnt",   64'(gnt), 64'd0);

      // single read
      req_vld = 4'b0001; req_addr[0] = 32'd128;
      #1 chk("t1_gnt", 64'(gnt), 64'b0001);
      tick(); req_vld = '0;
      chk("t1_rden",   64'(rden), 64'd1);
      chk("t1_rdaddr", 64'(rdaddr), 64'd128);
      chk("t1_wren",   64'(wren), 64'd0);
      tick();
      chk("t1_rden_off", 64'(rden), 64'd0);
      chk("t1_rsp_early", 64'(rsp_vld), 64'd0);
      tick();
      chk("t1_rsp",   64'(rsp_vld), 64'b0001);
      chk("t1_rdata", rsp_rdata, 64'hC0DE0000_00000080);
      tick();
      chk("t1_rsp_once", 64'(rsp_vld), 64'd0);

      // all four held from reset
      do_reset();
      req_vld = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1 chk($sformatf("t2_gnt%0d", i), 64'(gnt), 64'(4'b0001 << (i % 4)));
         tick();
      end
      req_vld = '0;
      tick();
      chk("t2_cnt", 64'(cnt), 64'd8);

      // wrap/skip: drive ptr to 3 via a ch2 grant
      req_vld = 4'b0100;
      #1 chk("t3_pre", 64'(gnt), 64'b0100);
      tick(); req_vld = 4'b0101;
      #1 chk("t3_wrap", 64'(gnt), 64'b0001);
      tick(); req_vld = 4'b0100;
      #1 chk("t3_skip", 64'(gnt), 64'b0100);
      tick(); req_vld = 4'b1001;
      #1 chk("t3_ptr3", 64'(gnt), 64'b1000);
      tick(); req_vld = '0;
      chk("t3_cnt", 64'(cnt), 64'd10);

      // mixed write then read of the same address
      req_vld = 4'b0010; req_we = 4'b0010; req_addr[1] = 32'h40; req_wdata[1] = 64'hA5;
      #1 chk("t4_wgnt", 64'(gnt), 64'b0010);
      tick();
      req_vld = 4'b0100; req_we = '0; req_addr[2] = 32'h40;
      chk("t4_wren",   64'(wren), 64'd1);
      chk("t4_wraddr", 64'(wraddr), 64'h40);
      chk("t4_wdata",  wdata, 64'hA5);
      chk("t4_rden0",  64'(rden), 64'd0);
      #1 chk("t4_rgnt", 64'(gnt), 64'b0100);
      tick(); req_vld = '0;
      chk("t4_rden",   64'(rden), 64'd1);
      chk("t4_rdaddr", 64'(rdaddr), 64'h40);
      chk("t4_wren0",  64'(wren), 64'd0);
      chk("t4_wrhold", 64'(wraddr), 64'h40);
      tick();
      chk("t4_norsp", 64'(rsp_vld), 64'd0);
      tick();
      chk("t4_rsp",   64'(rsp_vld), 64'b0100);
      chk("t4_rdata", rsp_rdata, 64'hA5);

      // back-to-back reads (ptr=3 -> ch0 then ch1)
      tick();
      req_vld = 4'b0011; req_addr[0] = 32'd10; req_addr[1] = 32'd20;
      #1 chk("bb_gnt0", 64'(gnt), 64'b0001);
      tick(); req_vld = 4'b0010;
      #1 chk("bb_gnt1", 64'(gnt), 64'b0010);
      tick(); req_vld = '0;
      tick();
      chk("bb_rsp0",  64'(rsp_vld), 64'b0001);
      chk("bb_data0", rsp_rdata, 64'hC0DE0000_0000000A);
      tick();
      chk("bb_rsp1",  64'(rsp_vld), 64'b0010);
      chk("bb_data1", rsp_rdata, 64'hC0DE0000_00000014);
      tick();

      // reset mid-flight
      req_vld = 4'b0001; req_addr[0] = 32'd128;
      #1 chk("t5_gnt", 64'(gnt), 64'b0001);
      tick(); req_vld = '0; rst_n = 1'b0;
      chk("t5_rden_pre", 64'(rden), 64'd1);
      tick(); rst_n = 1'b1;
      chk("t5_rden",   64'(rden), 64'd0);
      chk("t5_rdaddr", 64'(rdaddr), 64'd0);
      chk("t5_wraddr", 64'(wraddr), 64'd0);
      chk("t5_wdata",  wdata, 64'd0);
      chk("t5_cnt",    64'(cnt), 64'd0);
      chk("t5_rsp0",   64'(rsp_vld), 64'd0);
      tick();
      chk("t5_rsp1",   64'(rsp_vld), 64'd0);
      req_vld = 4'b1001;
      #1 chk("t5_ptr0", 64'(gnt), 64'b0001);
      tick(); req_vld = '0;

      // saturation on the CNT_WIDTH=4 instance
      do_reset();
      req_vld = 4'b0011;
      for (int i = 0; i < 15; i++) tick();
      chk("t6_cnt15", 64'(s_cnt), 64'd15);
      for (int i = 0; i < 5; i++) tick();
      req_vld = '0;
      chk("t6_sat",  64'(s_cnt), 64'd15);
      chk("t6_wide", 64'(cnt), 64'd20);
      tick();
      chk("t6_hold", 64'(s_cnt), 64'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
